bench_bist_ctrl: RTL and testbench

BENCH_BIST_CTRL -- requirements
Module: bench_bist_ctrl

---
 rtl/bench_bist_ctrl.sv | 110 +++++++++++
 tb/tb_bench_bist_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl: LFSR-stimulus / MISR-compaction BIST sequencer for a 3-input, 6-output benchmark circuit
module bench_bist_ctrl #(
  parameter int          PAT_LEN    = 1024,
  parameter int          INIT_CYC   = 2,
  parameter int          DRAIN_CYC  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        dut_g0,
  output logic        dut_g1,
  output logic        dut_g2,
  input  logic [5:0]  dut_resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, CMP} state_t;
  localparam logic [15:0] L_INIT  = 16'(INIT_CYC - 1);
  localparam logic [15:0] L_PAT   = 16'(PAT_LEN - 1);
  localparam logic [15:0] L_DRAIN = 16'((DRAIN_CYC == 0) ? 0 : DRAIN_CYC - 1);
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_lfsr;
  logic [15:0] r_misr;
  logic        r_g0;
  logic        r_g1;
  logic        r_g2;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [15:0] w_lfsr_nxt;
  logic [15:0] w_misr_nxt;
  logic        w_last;
  assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  assign w_misr_nxt = {r_misr[14:0], r_misr[15] ^ r_misr[14] ^ r_misr[12] ^ r_misr[3]} ^ {10'b0, dut_resp};
  assign w_last     = (r_cnt == 16'd0);
  assign dut_g0     = r_g0;
  assign dut_g1     = r_g1;
  assign dut_g2     = r_g2;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign signature  = r_misr;
  // Phase sequencer: one shared down-counter times every phase; outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lfsr  <= LFSR_SEED;
      r_misr  <= '0;
      r_g0    <= 1'b0;
      r_g1    <= 1'b0;
      r_g2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= INIT;
          r_cnt   <= L_INIT;
          r_lfsr  <= LFSR_SEED;
          r_misr  <= '0;
          r_pass  <= 1'b0;
          r_busy  <= 1'b1;
          r_g0    <= 1'b1;
        end
        INIT: if (w_last) begin
          r_state <= RUN;
          r_cnt   <= L_PAT;
          r_g0    <= 1'b0;
          r_g1    <= r_lfsr[0];
          r_g2    <= r_lfsr[1];
        end else r_cnt <= r_cnt - 16'd1;
        RUN: begin
          r_lfsr <= w_lfsr_nxt;
          r_misr <= w_misr_nxt;
          if (w_last) begin
            r_state <= (DRAIN_CYC == 0) ? CMP : DRAIN;
            r_cnt   <= L_DRAIN;
            r_g1    <= 1'b0;
            r_g2    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 16'd1;
            r_g1  <= w_lfsr_nxt[0];
            r_g2  <= w_lfsr_nxt[1];
          end
        end
        DRAIN: begin
          r_misr <= w_misr_nxt;
          if (w_last) r_state <= CMP;
          else r_cnt <= r_cnt - 16'd1;
        end
        CMP: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_pass  <= (r_misr == GOLDEN_SIG);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb_bench_bist_ctrl: directed checks of bench_bist_ctrl across four parameterisations
module tb_bench_bist_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic [3:0]  start_v = '0;
  logic [3:0]  g0_v, g1_v, g2_v, busy_v, done_v, pass_v;
  logic [15:0] sig_v [4];
  logic [1:0]  stim [5];
  logic [1:0]  exp_stim [5] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10};
  logic        init_busy, init_g0, init_pass, acc;
  int          n_tests = 0;
  int          n_fail = 0;
  int          edges, g0n;
  logic [15:0] sig, sig1;
  logic        ps;

  always #5 clk = ~clk;

  // A: defaults, B: other golden value, C: single pattern no drain, D: short run with drain
  bench_bist_ctrl u_a (.clk(clk), .rst(rst), .start(start_v[0]), .dut_g0(g0_v[0]), .dut_g1(g1_v[0]), .dut_g2(g2_v[0]),
    .dut_resp(6'h00), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .signature(sig_v[0]));
  bench_bist_ctrl #(.GOLDEN_SIG(16'h1234)) u_b (.clk(clk), .rst(rst), .start(start_v[1]), .dut_g0(g0_v[1]),
    .dut_g1(g1_v[1]), .dut_g2(g2_v[1]), .dut_resp(6'h00), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .signature(sig_v[1]));
  bench_bist_ctrl #(.PAT_LEN(1), .DRAIN_CYC(0)) u_c (.clk(clk), .rst(rst), .start(start_v[2]), .dut_g0(g0_v[2]),
    .dut_g1(g1_v[2]), .dut_g2(g2_v[2]), .dut_resp(6'h01), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .signature(sig_v[2]));
  bench_bist_ctrl #(.INIT_CYC(1), .PAT_LEN(4), .DRAIN_CYC(2)) u_d (.clk(clk), .rst(rst), .start(start_v[3]),
    .dut_g0(g0_v[3]), .dut_g1(g1_v[3]), .dut_g2(g2_v[3]), .dut_resp(6'h21), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .signature(sig_v[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a start on instance sel, then follow the run until done, pulsing start at cycles p1/p2
  task automatic run(input int sel, input int ninit, input int p1, input int p2,
                     output int e, output int gn, output logic [15:0] s, output logic p);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
    init_busy = busy_v[sel];
    init_g0   = g0_v[sel];
    init_pass = pass_v[sel];
    e = 0; gn = 0; s = '0; p = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!hold) start_v[sel] = (c == p1 || c == p2);
      gn += int'(g0_v[sel]);
      if (c >= ninit && c < ninit + 5) stim[c - ninit] = {g2_v[sel], g1_v[sel]};
      if (done_v[sel]) begin
        e = c + 1;
        s = sig_v[sel];
        p = pass_v[sel];
        break;
      end
    end
    if (e == 0) chk("run_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_stim(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s_%0d", tag, i), 32'(stim[i]), 32'(exp_stim[i]));
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    start_v[0] = 1'b1;
    #12;
    chk("rst_busy", 32'(busy_v[0]), 32'd0);
    chk("rst_done", 32'(done_v[0]), 32'd0);
    chk("rst_pass", 32'(pass_v[0]), 32'd0);
    chk("rst_sig", 32'(sig_v[0]), 32'd0);
    chk("rst_g", 32'({g0_v[0], g1_v[0], g2_v[0]}), 32'd0);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run(0, 2, -1, -1, edges, g0n, sig, ps);
    chk("a_edges", 32'(edges), 32'd1030);
    chk("a_g0_cycles", 32'(g0n), 32'd2);
    chk("a_init_busy", 32'(init_busy), 32'd1);
    chk("a_init_g0", 32'(init_g0), 32'd1);
    chk("a_sig", 32'(sig), 32'h0000);
    chk("a_pass", 32'(ps), 32'd1);
    chk_stim("a_stim");
    @(negedge clk);
    chk("a_done_width", 32'(done_v[0]), 32'd0);
    chk("a_idle_busy", 32'(busy_v[0]), 32'd0);
    run(1, 2, -1, -1, edges, g0n, sig, ps);
    chk("b_edges", 32'(edges), 32'd1030);
    chk("b_sig", 32'(sig), 32'h0000);
    chk("b_pass", 32'(ps), 32'd0);
    @(negedge clk);
    chk("b_done_width", 32'(done_v[1]), 32'd0);
    run(2, 2, -1, -1, edges, g0n, sig, ps);
    chk("c_edges", 32'(edges), 32'd5);
    chk("c_sig", 32'(sig), 32'h0001);
    chk("c_pass", 32'(ps), 32'd0);
    run(3, 1, -1, -1, edges, g0n, sig, ps);
    chk("d_edges", 32'(edges), 32'd9);
    chk("d_sig", 32'(sig), 32'h07DC);
    @(negedge clk);
    run(0, 2, 500, 1028, edges, g0n, sig, ps);
    chk("ign_edges", 32'(edges), 32'd1030);
    chk("ign_sig", 32'(sig), 32'h0000);
    chk("ign_pass", 32'(ps), 32'd1);
    acc = 1'b0;
    repeat (5) begin
      @(negedge clk);
      acc |= busy_v[0] | done_v[0];
    end
    chk("ign_no_extra_run", 32'(acc), 32'd0);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (502) @(negedge clk);
    chk("abort_busy_before", 32'(busy_v[0]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_g", 32'({g0_v[0], g1_v[0], g2_v[0]}), 32'd0);
    chk("abort_pass", 32'(pass_v[0]), 32'd0);
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc |= done_v[0] | busy_v[0];
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      acc |= done_v[0] | busy_v[0];
    end
    chk("abort_no_done", 32'(acc), 32'd0);
    run(0, 2, -1, -1, edges, g0n, sig, ps);
    chk("restart_edges", 32'(edges), 32'd1030);
    chk("restart_g0_cycles", 32'(g0n), 32'd2);
    chk("restart_sig", 32'(sig), 32'h0000);
    chk_stim("restart_stim");
    @(negedge clk);
    hold = 1'b1;
    run(0, 2, -1, -1, edges, g0n, sig1, ps);
    chk("hold1_edges", 32'(edges), 32'd1030);
    chk("hold1_pass", 32'(ps), 32'd1);
    chk("hold1_sig", 32'(sig1), 32'h0000);
    run(0, 2, -1, -1, edges, g0n, sig, ps);
    chk("hold2_init_busy", 32'(init_busy), 32'd1);
    chk("hold2_init_g0", 32'(init_g0), 32'd1);
    chk("hold2_pass_cleared", 32'(init_pass), 32'd0);
    chk("hold2_edges", 32'(edges), 32'd1030);
    chk("hold2_sig", 32'(sig), 32'h0000);
    chk("hold2_pass", 32'(ps), 32'd1);
    chk_stim("hold2_stim");
    start_v[0] = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("hold_end_idle", 32'(busy_v[0]), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
